// File: rtl/hs_bus_arbiter.sv
// hs_bus_arbiter: round-robin arbiter of NCH four-phase producer channels onto one
// valid/ack consumer bus, with a bus-side timeout that aborts hung transfers.
module hs_bus_arbiter #(
    parameter int WIDTH   = 64,
    parameter int NCH     = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH-1:0]         req,
    input  logic [NCH*WIDTH-1:0]   data_in,
    output logic [NCH-1:0]         ack,
    output logic                   bus_valid,
    output logic [WIDTH-1:0]       bus_data,
    output logic [$clog2(NCH)-1:0] bus_src,
    input  logic                   bus_ack,
    output logic                   timeout_err,
    output logic [$clog2(NCH)-1:0] err_src,
    output logic [7:0]             err_cnt
);
    localparam int SW = $clog2(NCH);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TIMER_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {IDLE, SEND, RTZ} stateT;

    stateT          state;
    logic [SW-1:0]  last;
    logic [TW-1:0]  timer;
    logic [SW-1:0]  winner;
    logic [SW-1:0]  cand;
    logic           found;
    logic [WIDTH-1:0] words [NCH];

    for (genvar i = 0; i < NCH; i++) begin : gWords
        assign words[i] = data_in[i*WIDTH +: WIDTH];
    end

    // Scan channels starting one past the last served channel, wrapping around.
    always_comb begin
        winner = '0;
        cand   = '0;
        found  = 1'b0;
        for (int unsigned k = 1; k <= NCH; k++) begin
            cand = SW'((32'(last) + k) % NCH);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            last        <= SW'(NCH - 1);
            timer       <= '0;
            ack         <= '0;
            bus_valid   <= 1'b0;
            bus_data    <= '0;
            bus_src     <= '0;
            timeout_err <= 1'b0;
            err_src     <= '0;
            err_cnt     <= '0;
        end else begin
            timeout_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        bus_data  <= words[winner];
                        bus_src   <= winner;
                        timer     <= '0;
                        bus_valid <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    // A bus_ack coinciding with expiry wins over the abort.
                    if (bus_ack) begin
                        bus_valid    <= 1'b0;
                        ack[bus_src] <= 1'b1;
                        state        <= RTZ;
                    end else if (TIMEOUT != 0 && timer == TIMER_LAST) begin
                        bus_valid    <= 1'b0;
                        ack[bus_src] <= 1'b1;
                        timeout_err  <= 1'b1;
                        err_src      <= bus_src;
                        if (err_cnt != 8'hFF) begin
                            err_cnt <= err_cnt + 8'd1;
                        end
                        state        <= RTZ;
                    end else if (TIMEOUT != 0) begin
                        timer <= timer + TW'(1);
                    end
                end
                RTZ: begin
                    if (!req[bus_src] && !bus_ack) begin
                        ack   <= '0;
                        last  <= bus_src;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
